// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
// Holds the 2-bit direction counter encodings, the default table size,
// and helpers that derive the tag and entry widths from the index width.
package branch_predictor_pkg;

  localparam int PC_W         = 32;
  localparam int IDX_BITS_DEF = 4;

  // Direction counter states: strongly/weakly not-taken, weakly/strongly taken.
  // The MSB of the counter is the predicted direction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // pc[1:0] is ignored and pc[idx_bits+1:2] indexes the table,
  // so the tag is whatever sits above the index.
  function automatic int tag_bits(input int idx_bits);
    return PC_W - idx_bits - 2;
  endfunction

  // One table entry: valid + tag + target + counter.
  function automatic int entry_bits(input int idx_bits);
    return 1 + tag_bits(idx_bits) + PC_W + 2;
  endfunction

  localparam int ENTRY_BITS = entry_bits(IDX_BITS_DEF);

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
// Ports:
//   ctr      - current counter value
//   taken    - resolved direction (1 = count up, 0 = count down)
//   ctr_next - updated value, clamped at CTR_SNT / CTR_ST
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with tagged target buffer and 2-bit
// saturating direction counters, plus resolved/mispredicted branch counters.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   fetch_pc                 - PC looked up combinationally
//   pred_taken, pred_target  - prediction for fetch_pc (target 0 if not taken)
//   upd_valid/pc/taken/target/pred - resolved branch from the branch unit
//   mispredict               - direction mismatch for the current update
//   branch_cnt, miss_cnt     - saturating statistics counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = tag_bits(IDX_BITS);

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]    fetch_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[31:IDX_BITS+2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[31:IDX_BITS+2];

  // Byte-offset bits never participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Flattened views of the per-entry registers for the read muxes.
  logic             valid_arr  [ENTRIES];
  logic [TAG_W-1:0] tag_arr    [ENTRIES];
  logic [31:0]      target_arr [ENTRIES];
  ctr_e             ctr_arr    [ENTRIES];

  // Lookup reads the registered table directly, so a same-cycle update
  // is only seen on the following cycle.
  logic fetch_hit;
  assign fetch_hit   = valid_arr[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
  assign pred_taken  = fetch_hit && ctr_arr[fetch_idx][1];
  assign pred_target = pred_taken ? target_arr[fetch_idx] : 32'h0;

  assign mispredict = upd_valid && (upd_taken != upd_pred);

  logic upd_hit;
  ctr_e ctr_next;
  assign upd_hit = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_arr[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      ctr_e             ctr_reg;
      logic             wr_sel;

      assign wr_sel = upd_valid && (upd_idx == IDX_BITS'(gi));

      // Tag/target are left alone in reset; valid=0 masks them.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= CTR_WNT;
        end else if (wr_sel) begin
          if (upd_hit) begin
            ctr_reg <= ctr_next;
            if (upd_taken) begin
              target_reg <= upd_target;
            end
          end else if (upd_taken) begin
            // Taken miss evicts whatever occupied this slot.
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= upd_target;
            ctr_reg    <= CTR_WT;
          end
        end
      end

      assign valid_arr[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign ctr_arr[gi]    = ctr_reg;
    end
  endgenerate

  logic [31:0] branch_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_reg <= 32'h0;
      miss_cnt_reg   <= 32'h0;
    end else if (upd_valid) begin
      if (branch_cnt_reg != 32'hFFFF_FFFF) begin
        branch_cnt_reg <= branch_cnt_reg + 32'h1;
      end
      if (mispredict && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'h1;
      end
    end
  end

  assign branch_cnt = branch_cnt_reg;
  assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: one task per scenario, inline checks.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int n_pass  = 0;
  int n_total = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_pred    (upd_pred),
    .mispredict  (mispredict),
    .branch_cnt  (branch_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic p);
    upd_valid  = v;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
    upd_pred   = p;
  endtask

  // Apply one update for one cycle, then idle the update port.
  task automatic do_upd(input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic p);
    set_upd(1'b1, pc, t, tgt, p);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    $display("update pc=%h taken=%0b tgt=%h pred=%0b -> branch_cnt=%0d miss_cnt=%0d",
             pc, t, tgt, p, branch_cnt, miss_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_pc = 32'h100;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h0) $display("FAIL reset_pred_target: got %h want 0", pred_target); else n_pass++;
    n_total++; if (branch_cnt !== 32'h0) $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
    n_total++; if (miss_cnt !== 32'h0) $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); else n_pass++;
    $display("reset: pred_taken=%0b pred_target=%h", pred_taken, pred_target);
  endtask

  task automatic test_allocate();
    fetch_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    #1;
    n_total++; if (mispredict !== 1'b1) $display("FAIL alloc_mispredict: got %0b want 1", mispredict); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL alloc_same_cycle_pred: got %0b want 0", pred_taken); else n_pass++;
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    n_total++; if (mispredict !== 1'b0) $display("FAIL idle_mispredict: got %0b want 0", mispredict); else n_pass++;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h200) $display("FAIL alloc_pred_target: got %h want 200", pred_target); else n_pass++;
    n_total++; if (miss_cnt !== 32'd1) $display("FAIL alloc_miss_cnt: got %0d want 1", miss_cnt); else n_pass++;
    n_total++; if (branch_cnt !== 32'd1) $display("FAIL alloc_branch_cnt: got %0d want 1", branch_cnt); else n_pass++;
    $display("allocate 0x100: pred_taken=%0b pred_target=%h", pred_taken, pred_target);
  endtask

  task automatic test_counter_sat();
    fetch_pc = 32'h100;
    // 10 -> 01 -> 00 -> 00
    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL nt1_pred: got %0b want 0", pred_taken); else n_pass++;
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL nt3_pred: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (branch_cnt !== 32'd4) $display("FAIL nt3_branch_cnt: got %0d want 4", branch_cnt); else n_pass++;
    n_total++; if (miss_cnt !== 32'd2) $display("FAIL nt3_miss_cnt: got %0d want 2", miss_cnt); else n_pass++;
    // 00 -> 01: still not taken if the floor held
    do_upd(32'h100, 1'b1, 32'h250, 1'b0);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL floor_pred: got %0b want 0", pred_taken); else n_pass++;
    // 01 -> 10: taken, target rewritten on hit
    do_upd(32'h100, 1'b1, 32'h250, 1'b0);
    n_total++; if (pred_target !== 32'h250) $display("FAIL hit_target: got %h want 250", pred_target); else n_pass++;
    // 10 -> 11 -> 11
    do_upd(32'h100, 1'b1, 32'h260, 1'b1);
    do_upd(32'h100, 1'b1, 32'h260, 1'b1);
    // 11 -> 10: still taken if the ceiling held; not-taken keeps target
    do_upd(32'h100, 1'b0, 32'hDEAD0, 1'b1);
    n_total++; if (pred_taken !== 1'b1) $display("FAIL ceil_pred: got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h260) $display("FAIL nt_keeps_target: got %h want 260", pred_target); else n_pass++;
    // 10 -> 01
    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL wt_to_wnt_pred: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (branch_cnt !== 32'd10) $display("FAIL sat_branch_cnt: got %0d want 10", branch_cnt); else n_pass++;
    n_total++; if (miss_cnt !== 32'd6) $display("FAIL sat_miss_cnt: got %0d want 6", miss_cnt); else n_pass++;
    // 01 -> 10 again, target 0x200
    do_upd(32'h100, 1'b1, 32'h200, 1'b0);
  endtask

  task automatic test_nt_miss_and_alias();
    // Not-taken miss on an aliasing PC must not evict 0x100.
    do_upd(32'h140, 1'b0, 32'h0, 1'b0);
    fetch_pc = 32'h100; #1;
    n_total++; if (pred_target !== 32'h200) $display("FAIL nt_miss_no_evict: got %h want 200", pred_target); else n_pass++;
    fetch_pc = 32'h140; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL nt_miss_no_alloc: got %0b want 0", pred_taken); else n_pass++;
    // Taken miss on the alias replaces the occupant.
    do_upd(32'h140, 1'b1, 32'h300, 1'b0);
    fetch_pc = 32'h100; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL alias_old_pred: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h0) $display("FAIL alias_old_target: got %h want 0", pred_target); else n_pass++;
    fetch_pc = 32'h140; #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL alias_new_pred: got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h300) $display("FAIL alias_new_target: got %h want 300", pred_target); else n_pass++;
    n_total++; if (branch_cnt !== 32'd13) $display("FAIL alias_branch_cnt: got %0d want 13", branch_cnt); else n_pass++;
    n_total++; if (miss_cnt !== 32'd8) $display("FAIL alias_miss_cnt: got %0d want 8", miss_cnt); else n_pass++;
  endtask

  task automatic test_ignore_invalid();
    set_upd(1'b0, 32'h108, 1'b1, 32'h500, 1'b0);
    #1;
    n_total++; if (mispredict !== 1'b0) $display("FAIL invalid_mispredict: got %0b want 0", mispredict); else n_pass++;
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    fetch_pc = 32'h108; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL invalid_no_alloc: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (branch_cnt !== 32'd13) $display("FAIL invalid_branch_cnt: got %0d want 13", branch_cnt); else n_pass++;
    $display("ignored update pc=108: pred_taken=%0b branch_cnt=%0d", pred_taken, branch_cnt);
  endtask

  task automatic test_back_to_back();
    fetch_pc = 32'h10C;
    set_upd(1'b1, 32'h10C, 1'b1, 32'h400, 1'b0);
    #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL b2b_same_cycle_pred: got %0b want 0", pred_taken); else n_pass++;
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL b2b_next_pred: got %0b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h400) $display("FAIL b2b_next_target: got %h want 400", pred_target); else n_pass++;
    fetch_pc = 32'h10F; #1;
    n_total++; if (pred_target !== 32'h400) $display("FAIL low_bits_ignored: got %h want 400", pred_target); else n_pass++;
    $display("back-to-back 0x10C: pred_taken=%0b pred_target=%h", pred_taken, pred_target);
  endtask

  task automatic test_cnt_saturate_and_reset();
    #1;
    force dut.branch_cnt_reg = 32'hFFFF_FFFE;
    force dut.miss_cnt_reg   = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_reg;
    release dut.miss_cnt_reg;
    do_upd(32'h120, 1'b0, 32'h0, 1'b1);
    n_total++; if (miss_cnt !== 32'hFFFF_FFFF) $display("FAIL miss_reach_max: got %h want ffffffff", miss_cnt); else n_pass++;
    n_total++; if (branch_cnt !== 32'hFFFF_FFFF) $display("FAIL branch_reach_max: got %h want ffffffff", branch_cnt); else n_pass++;
    do_upd(32'h120, 1'b0, 32'h0, 1'b1);
    n_total++; if (miss_cnt !== 32'hFFFF_FFFF) $display("FAIL miss_saturate: got %h want ffffffff", miss_cnt); else n_pass++;
    n_total++; if (branch_cnt !== 32'hFFFF_FFFF) $display("FAIL branch_saturate: got %h want ffffffff", branch_cnt); else n_pass++;
    // Reset wins over a simultaneous allocating update.
    rst = 1'b1;
    set_upd(1'b1, 32'h110, 1'b1, 32'h600, 1'b0);
    tick();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    fetch_pc = 32'h110; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL rst_discards_update: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (branch_cnt !== 32'h0) $display("FAIL rst_branch_cnt: got %h want 0", branch_cnt); else n_pass++;
    n_total++; if (miss_cnt !== 32'h0) $display("FAIL rst_miss_cnt: got %h want 0", miss_cnt); else n_pass++;
    fetch_pc = 32'h140; #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL rst_clears_valid: got %0b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 32'h0) $display("FAIL rst_clears_target_out: got %h want 0", pred_target); else n_pass++;
    $display("reset with update: branch_cnt=%0d miss_cnt=%0d", branch_cnt, miss_cnt);
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter_sat();
    test_nt_miss_and_alias();
    test_ignore_invalid();
    test_back_to_back();
    test_cnt_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
